// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the UART ROM loader.
// Loader/receiver state encodings, sync byte and frame width.
package rom_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         UART_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    DONE
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // A word count larger than the ROM would wrap the write address.
  function automatic logic len_too_big(
    input logic [15:0] n,
    input int          aw
  );
    return longint'(n) > (longint'(1) << aw);
  endfunction

endpackage

// File: rtl/rom_loader_uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer.
// Samples mid-bit; reports a good byte or a framing error.
module uart_rx
  import rom_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_BITS - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  rx_state_t     r_state;
  rx_state_t     w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_fall;
  logic          w_tick;

  // Synchronizer plus edge history; low reset so a line already low
  // at release is not mistaken for a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall = r_prev & ~r_sync2;
  assign w_tick = (r_state == RX_START) ? (r_cnt == HALF_M1)
                                        : (r_cnt == FULL_M1);

  // Receiver state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RX_IDLE;
    else        r_state <= w_next;
  end

  // Receiver next-state: glitch check at mid start bit.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_tick) w_next = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && r_bit == LAST_BIT) w_next = RX_STOP;
      RX_STOP:  if (w_tick) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  // Bit timer, bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (r_state == RX_IDLE || w_tick) r_cnt <= '0;
      else                              r_cnt <= r_cnt + CW'(1);
      if (r_state != RX_DATA) r_bit <= '0;
      else if (w_tick)        r_bit <= r_bit + 3'd1;
      if (r_state == RX_DATA && w_tick)
        r_shift <= {r_sync2, r_shift[7:1]};
    end
  end

  // Stop-bit sample decides between a good byte and a framing error.
  always_comb begin
    byte_valid = (r_state == RX_STOP) && w_tick &&  r_sync2;
    frame_err  = (r_state == RX_STOP) && w_tick && !r_sync2;
    byte_data  = r_shift;
  end

endmodule

// File: rtl/rom_loader.sv
// UART boot loader: sync byte, big-endian word count, then words.
// Writes the instruction ROM and holds the CPU in reset meanwhile.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);

  logic        w_bv;
  logic [7:0]  w_byte;
  logic        w_ferr;
  ld_state_t   r_state;
  ld_state_t   w_next;
  logic [15:0] w_len;
  logic        w_enter_len;
  logic        w_write;
  logic        w_zero;
  logic        w_big;
  logic        w_release;

  logic [7:0]        r_len_hi;
  logic [15:0]       r_left;
  logic [7:0]        r_hi;
  logic              r_we;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(w_bv),
    .byte_data (w_byte),
    .frame_err (w_ferr)
  );

  assign w_len = {r_len_hi, w_byte};

  // Loader state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= WAIT_SYNC;
    else        r_state <= w_next;
  end

  // Loader next-state; a framing error always resynchronises.
  always_comb begin
    w_next = r_state;
    if (w_ferr) begin
      w_next = WAIT_SYNC;
    end else if (w_bv) begin
      unique case (r_state)
        WAIT_SYNC: if (w_byte == SYNC_BYTE) w_next = LEN_HI;
        LEN_HI:    w_next = LEN_LO;
        LEN_LO: begin
          if (w_len == 16'd0)               w_next = DONE;
          else if (len_too_big(w_len, ADDR_W)) w_next = WAIT_SYNC;
          else                              w_next = DATA_HI;
        end
        DATA_HI:   w_next = DATA_LO;
        DATA_LO:   w_next = (r_left == 16'd1) ? DONE : DATA_HI;
        DONE:      if (w_byte == SYNC_BYTE) w_next = LEN_HI;
        default:   w_next = WAIT_SYNC;
      endcase
    end
  end

  // Per-byte strobes decoded from state and received byte.
  always_comb begin
    w_enter_len = w_bv && (w_byte == SYNC_BYTE) &&
                  (r_state == WAIT_SYNC || r_state == DONE);
    w_write     = w_bv && (r_state == DATA_LO);
    w_zero      = w_bv && (r_state == LEN_LO) && (w_len == 16'd0);
    w_big       = w_bv && (r_state == LEN_LO) &&
                  len_too_big(w_len, ADDR_W);
    w_release   = (r_we && r_last) || w_zero;
  end

  // Datapath: length, word assembly, ROM port and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len_hi  <= '0;
      r_left    <= '0;
      r_hi      <= '0;
      r_we      <= 1'b0;
      r_last    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_bv && r_state == LEN_HI) r_len_hi <= w_byte;
      if (w_bv && r_state == LEN_LO) r_left <= w_len;
      else if (w_write)              r_left <= r_left - 16'd1;
      if (w_bv && r_state == DATA_HI) r_hi <= w_byte;
      r_we <= w_write;
      if (w_write) begin
        r_wdata <= {r_hi, w_byte};
        r_last  <= (r_left == 16'd1);
      end
      // Saturate so a full-size load never wraps back to 0.
      if (w_enter_len)               r_addr <= '0;
      else if (r_we && r_addr != '1) r_addr <= r_addr + 1'b1;
      if (w_ferr || w_big) r_err <= 1'b1;
      // Release one cycle after the final write; any exit from DONE holds.
      if (w_next != DONE) begin
        r_cpu_rst <= 1'b1;
        r_done    <= 1'b0;
      end else if (w_release) begin
        r_cpu_rst <= 1'b0;
        r_done    <= 1'b1;
      end
    end
  end

  assign rom_we    = r_we;
  assign rom_addr  = r_addr;
  assign rom_wdata = r_wdata;
  assign cpu_reset = r_cpu_rst;
  assign load_done = r_done;
  assign load_err  = r_err;

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 The block SHALL have parameter ADDR_W, default 15, meaning the instruction-ROM address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx, input, 1 bit: the UART serial line, idle high, 8N1, LSB first.
REQ-006 The block SHALL have port rom_we, output, 1 bit: the instruction-ROM write strobe, one cycle per word.
REQ-007 The block SHALL have port rom_addr, output, ADDR_W bits: the ROM write address.
REQ-008 The block SHALL have port rom_wdata, output, 16 bits: the instruction word to write.
REQ-009 The block SHALL have port cpu_reset, output, 1 bit: active-high hold on the computer; it is 1 whenever no load has completed or a load is in progress.
REQ-010 The block SHALL have port load_done, output, 1 bit: 1 while the loaded program is released to run.
REQ-011 The block SHALL have port load_err, output, 1 bit: sticky error flag (framing error or oversize length).

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The receiver SHALL:
- detect the falling edge of the start bit;
- re-check the line at mid start bit and treat a high line as a glitch, returning to idle;
- sample each data bit every CLKS_PER_BIT cycles at mid-bit;
- raise a 1-cycle byte_valid after the stop-bit sample.
REQ-014 A stop bit sampled as 0 SHALL produce no byte_valid; it sets load_err and forces the loader FSM to WAIT_SYNC.
REQ-015 The loader FSM states SHALL be WAIT_SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE.
REQ-016 In WAIT_SYNC, a byte equal to 0xA5 SHALL advance the FSM to LEN_HI; any other byte is ignored.
REQ-017 LEN_HI and LEN_LO SHALL capture a 16-bit big-endian word count N, and rom_addr SHALL be cleared to 0 on entry to LEN_HI.
REQ-018 After LEN_LO, the next state SHALL depend on N:
- N=0 goes to DONE;
- N>2^ADDR_W sets load_err and goes to WAIT_SYNC;
- otherwise the FSM goes to DATA_HI.
REQ-019 DATA_HI SHALL latch the high byte, and DATA_LO SHALL latch the low byte.
REQ-020 On the cycle after the low byte's byte_valid, rom_we SHALL be 1 for exactly one cycle, with rom_wdata={hi,lo} and the current rom_addr.
REQ-021 rom_addr SHALL increment by 1 on the cycle after each write pulse and SHALL never wrap within a load; N is limited by REQ-018.
REQ-022 After the Nth write the FSM SHALL enter DONE; cpu_reset SHALL fall and load_done SHALL rise on the cycle after that final rom_we pulse.
REQ-023 In DONE, a received 0xA5 SHALL raise cpu_reset, clear load_done in the next cycle and enter LEN_HI (reload); other bytes are ignored.
REQ-024 rom_we, rom_addr and rom_wdata SHALL be registered outputs, and rom_wdata SHALL hold its last value when rom_we=0.
REQ-025 load_err SHALL be cleared only by reset; it does not block subsequent loads.

Reset
REQ-026 Asserting reset (low) at any time, including mid-byte or mid-load, SHALL asynchronously force:
- FSM to WAIT_SYNC and receiver to idle;
- rom_we=0, rom_addr=0, rom_wdata=0;
- cpu_reset=1, load_done=0, load_err=0.
REQ-027 After reset release, the first byte considered SHALL be one whose start bit begins after release.

Structure
REQ-028 A shared package SHALL hold the loader state enum, the SYNC_BYTE=0xA5 constant and the UART bit-count constant.
REQ-029 The receiver SHALL be a sub-module uart_rx (ports: clk, reset, rx, byte_valid, byte_data, frame_err), with the loader FSM in rom_loader.

Verification (CLKS_PER_BIT=4 in simulation)
REQ-030 Sending bytes A5 00 04 00 0F EC 10 40 00 E3 08 SHALL produce four rom_we pulses: addr 0..3, data 000F, EC10, 4000, E308. cpu_reset SHALL fall on the cycle after the 4th pulse, load_done=1, load_err=0.
REQ-031 Sending 33 7F A5 00 00 SHALL ignore the first two bytes, produce no rom_we, and set load_done=1 with cpu_reset=0 after the final byte.
REQ-032 A framing error injected in the 2nd data word's low byte SHALL produce exactly one write (addr 0), load_err=1 and cpu_reset stuck at 1; a following valid 1-word load SHALL succeed with load_err still 1.
REQ-033 Sending A5 80 01 with ADDR_W=15 (N=0x8001) SHALL set load_err=1, produce no writes, and leave the FSM in WAIT_SYNC.
REQ-034 reset pulsed low mid-way through word 2 SHALL immediately show all REQ-026 values; the next load SHALL write from addr 0.
REQ-035 A5 00 01 12 34 sent while in DONE SHALL raise cpu_reset, write 0x1234 at addr 0, then release cpu_reset.
